// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 key constants and the prefix-tracking state type
// used by the command assembler.
package ps2_keys_pkg;

    localparam int MAX_CHARS = 4;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic [1:0] {
        NORMAL,
        BREAK,
        EXT,
        EXT_BREAK
    } prefix_e;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup for letters A-Z and digits 0-9.
// Every other code returns 8'h00, which callers treat as "unmapped".
module scancode_to_ascii (
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = 8'h41; // A
            8'h32: ascii_o = 8'h42;
            8'h21: ascii_o = 8'h43;
            8'h23: ascii_o = 8'h44;
            8'h24: ascii_o = 8'h45;
            8'h2B: ascii_o = 8'h46;
            8'h34: ascii_o = 8'h47;
            8'h33: ascii_o = 8'h48;
            8'h43: ascii_o = 8'h49;
            8'h3B: ascii_o = 8'h4A;
            8'h42: ascii_o = 8'h4B;
            8'h4B: ascii_o = 8'h4C;
            8'h3A: ascii_o = 8'h4D;
            8'h31: ascii_o = 8'h4E;
            8'h44: ascii_o = 8'h4F;
            8'h4D: ascii_o = 8'h50;
            8'h15: ascii_o = 8'h51;
            8'h2D: ascii_o = 8'h52;
            8'h1B: ascii_o = 8'h53;
            8'h2C: ascii_o = 8'h54;
            8'h3C: ascii_o = 8'h55;
            8'h2A: ascii_o = 8'h56;
            8'h1D: ascii_o = 8'h57;
            8'h22: ascii_o = 8'h58;
            8'h35: ascii_o = 8'h59;
            8'h1A: ascii_o = 8'h5A; // Z
            8'h45: ascii_o = 8'h30; // 0
            8'h16: ascii_o = 8'h31;
            8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;
            8'h25: ascii_o = 8'h34;
            8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;
            8'h3D: ascii_o = 8'h37;
            8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39; // 9
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_command_assembler.sv
// Turns a raw PS/2 scan byte stream into an editable line buffer and, on Enter,
// hands the buffered characters to the processor as one packed command word.
module ps2_command_assembler #(
    parameter int MAX_CHARS = ps2_keys_pkg::MAX_CHARS,
    parameter int CNT_W     = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             scan_data,
    input  logic                   scan_valid,
    output logic [8*MAX_CHARS-1:0] buf_word,
    output logic [CNT_W-1:0]       buf_count,
    output logic [8*MAX_CHARS-1:0] cmd_word,
    output logic [CNT_W-1:0]       cmd_len,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   overflow
);

    import ps2_keys_pkg::*;

    localparam int W = 8 * MAX_CHARS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_CHARS);

    prefix_e          state_q, state_d;
    logic [W-1:0]     buf_word_q, buf_word_d;
    logic [CNT_W-1:0] buf_count_q, buf_count_d;
    logic [W-1:0]     cmd_word_q, cmd_word_d;
    logic [CNT_W-1:0] cmd_len_q, cmd_len_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             overflow_q, overflow_d;
    logic             key_evt;
    logic [7:0]       ascii;

    scancode_to_ascii u_lut (
        .code_i  (scan_data),
        .ascii_o (ascii)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= NORMAL;
            buf_word_q  <= '0;
            buf_count_q <= '0;
            cmd_word_q  <= '0;
            cmd_len_q   <= '0;
            cmd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_word_q  <= buf_word_d;
            buf_count_q <= buf_count_d;
            cmd_word_q  <= cmd_word_d;
            cmd_len_q   <= cmd_len_d;
            cmd_valid_q <= cmd_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_word_d  = buf_word_q;
        buf_count_d = buf_count_q;
        cmd_word_d  = cmd_word_q;
        cmd_len_d   = cmd_len_q;
        cmd_valid_d = cmd_valid_q;
        overflow_d  = 1'b0;
        key_evt     = 1'b0;

        // Prefix bytes and the byte following them never reach the key logic.
        if (scan_valid) begin
            case (state_q)
                NORMAL: begin
                    if (scan_data == SC_BREAK)    state_d = BREAK;
                    else if (scan_data == SC_EXT) state_d = EXT;
                    else                          key_evt = 1'b1;
                end
                BREAK:     state_d = NORMAL;
                EXT:       state_d = (scan_data == SC_BREAK) ? EXT_BREAK : NORMAL;
                EXT_BREAK: state_d = NORMAL;
                default:   state_d = NORMAL;
            endcase
        end

        if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;

        if (key_evt) begin
            if (scan_data == SC_ENTER) begin
                if (buf_count_q != '0) begin
                    // A retiring command frees the slot in the same cycle.
                    if (!cmd_valid_q || cmd_ready) begin
                        cmd_word_d  = buf_word_q;
                        cmd_len_d   = buf_count_q;
                        cmd_valid_d = 1'b1;
                        buf_word_d  = '0;
                        buf_count_d = '0;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end else if (scan_data == SC_BKSP) begin
                if (buf_count_q != '0) begin
                    buf_word_d  = {8'h00, buf_word_q[W-1:8]};
                    buf_count_d = buf_count_q - 1'b1;
                end
            end else if (ascii != 8'h00) begin
                if (buf_count_q < FULL_CNT) begin
                    buf_word_d  = {buf_word_q[W-9:0], ascii};
                    buf_count_d = buf_count_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    assign buf_word  = buf_word_q;
    assign buf_count = buf_count_q;
    assign cmd_word  = cmd_word_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_valid = cmd_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_command_assembler.sv
// Scoreboard bench for ps2_command_assembler: stimulus queues expected status
// snapshots and committed commands; a negedge monitor pops and compares them.
module tb_ps2_command_assembler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  scan_data = 8'h00;
    logic        scan_valid = 1'b0;
    logic [31:0] buf_word;
    logic [2:0]  buf_count;
    logic [31:0] cmd_word;
    logic [2:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        overflow;

    ps2_command_assembler #(.MAX_CHARS(4), .CNT_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .buf_word   (buf_word),
        .buf_count  (buf_count),
        .cmd_word   (cmd_word),
        .cmd_len    (cmd_len),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        full;
        logic [31:0] w;
        logic [2:0]  c;
        logic [31:0] cw;
        logic [2:0]  cl;
        logic        v;
        logic        o;
        int          id;
    } snap_t;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  l;
    } cmd_t;

    snap_t chk_q[$];
    cmd_t  cmd_q[$];
    int    tests = 0;
    int    fails = 0;
    int    nid   = 0;
    bit    done  = 1'b0;

    task automatic push_snap(input logic full, input logic [31:0] w, input logic [2:0] c,
                             input logic [31:0] cw, input logic [2:0] cl,
                             input logic v, input logic o);
        snap_t s;
        s.full = full; s.w = w; s.c = c; s.cw = cw; s.cl = cl; s.v = v; s.o = o;
        s.id = nid;
        nid++;
        chk_q.push_back(s);
    endtask

    // Byte with only the overflow pulse checked (prefixes and break targets).
    task automatic send(input logic [7:0] b, input logic o);
        @(posedge clock); #1;
        scan_data = b; scan_valid = 1'b1;
        @(posedge clock); #1;
        scan_valid = 1'b0;
        push_snap(1'b0, '0, '0, '0, '0, 1'b0, o);
    endtask

    task automatic sendc(input logic [7:0] b, input logic [31:0] w, input logic [2:0] c,
                         input logic [31:0] cw, input logic [2:0] cl,
                         input logic v, input logic o);
        @(posedge clock); #1;
        scan_data = b; scan_valid = 1'b1;
        @(posedge clock); #1;
        scan_valid = 1'b0;
        push_snap(1'b1, w, c, cw, cl, v, o);
    endtask

    task automatic accept(input logic [31:0] w, input logic [2:0] l);
        cmd_t e;
        e.w = w; e.l = l;
        cmd_q.push_back(e);
        @(posedge clock); #1;
        cmd_ready = 1'b1;
        @(posedge clock); #1;
        cmd_ready = 1'b0;
    endtask

    task automatic pulse_reset(input logic [7:0] junk);
        @(posedge clock); #1;
        reset = 1'b1; scan_data = junk; scan_valid = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; scan_valid = 1'b0;
        push_snap(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        snap_t s;
        cmd_t  e;
        if (cmd_valid && cmd_ready) begin
            tests++;
            if (cmd_q.size() == 0) begin
                fails++;
                $display("FAIL cmd_transfer: got %h/%0d, required no pending command", cmd_word, cmd_len);
            end else begin
                e = cmd_q.pop_front();
                if (cmd_word !== e.w || cmd_len !== e.l) begin
                    fails++;
                    $display("FAIL cmd_transfer: got %h/%0d, required %h/%0d", cmd_word, cmd_len, e.w, e.l);
                end
            end
        end
        if (chk_q.size() != 0) begin
            s = chk_q.pop_front();
            tests++;
            if (overflow !== s.o) begin
                fails++;
                $display("FAIL snap%0d overflow: got %b, required %b", s.id, overflow, s.o);
            end
            if (s.full) begin
                tests++;
                if (buf_word !== s.w || buf_count !== s.c) begin
                    fails++;
                    $display("FAIL snap%0d buffer: got %h/%0d, required %h/%0d", s.id, buf_word, buf_count, s.w, s.c);
                end
                tests++;
                if (cmd_valid !== s.v || cmd_word !== s.cw || cmd_len !== s.cl) begin
                    fails++;
                    $display("FAIL snap%0d command: got v=%b %h/%0d, required v=%b %h/%0d",
                             s.id, cmd_valid, cmd_word, cmd_len, s.v, s.cw, s.cl);
                end
            end
        end else if (!reset && overflow) begin
            tests++;
            fails++;
            $display("FAIL stray_overflow: got 1, required 0");
        end
        if (done) begin
            tests++;
            if (chk_q.size() != 0 || cmd_q.size() != 0) begin
                fails++;
                $display("FAIL leftover: got %0d snaps %0d cmds, required 0 0", chk_q.size(), cmd_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pulse_reset(8'h00);

        // F, 2 with breaks, then Enter
        sendc(8'h2B, 32'h46, 3'd1, 32'h0, 3'd0, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h2B, 1'b0);
        sendc(8'h1E, 32'h4632, 3'd2, 32'h0, 3'd0, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h1E, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h4632, 3'd2, 1'b1, 1'b0);
        send(8'hF0, 1'b0); send(8'h5A, 1'b0);
        accept(32'h4632, 3'd2);
        push_snap(1'b1, 32'h0, 3'd0, 32'h4632, 3'd2, 1'b0, 1'b0);

        // Fill to four characters, fifth overflows
        sendc(8'h2B, 32'h46, 3'd1, 32'h4632, 3'd2, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h2B, 1'b0);
        sendc(8'h23, 32'h4644, 3'd2, 32'h4632, 3'd2, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h23, 1'b0);
        sendc(8'h16, 32'h464431, 3'd3, 32'h4632, 3'd2, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h16, 1'b0);
        sendc(8'h45, 32'h46443130, 3'd4, 32'h4632, 3'd2, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h45, 1'b0);
        sendc(8'h22, 32'h46443130, 3'd4, 32'h4632, 3'd2, 1'b0, 1'b1);
        send(8'hF0, 1'b0); send(8'h22, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h46443130, 3'd4, 1'b1, 1'b0);
        accept(32'h46443130, 3'd4);
        push_snap(1'b1, 32'h0, 3'd0, 32'h46443130, 3'd4, 1'b0, 1'b0);

        // Backspace editing down past empty, then Enter on empty
        sendc(8'h2D, 32'h52, 3'd1, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h46, 32'h5239, 3'd2, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h66, 32'h52, 3'd1, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h66, 32'h0, 3'd0, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h66, 32'h0, 3'd0, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h46443130, 3'd4, 1'b0, 1'b0);

        // Enter while a command is pending is dropped
        sendc(8'h1C, 32'h41, 3'd1, 32'h46443130, 3'd4, 1'b0, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h41, 3'd1, 1'b1, 1'b0);
        sendc(8'h32, 32'h42, 3'd1, 32'h41, 3'd1, 1'b1, 1'b0);
        sendc(8'h5A, 32'h42, 3'd1, 32'h41, 3'd1, 1'b1, 1'b1);
        accept(32'h41, 3'd1);
        push_snap(1'b1, 32'h42, 3'd1, 32'h41, 3'd1, 1'b0, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h42, 3'd1, 1'b1, 1'b0);
        accept(32'h42, 3'd1);
        push_snap(1'b1, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);

        // Enter coinciding with the retiring handshake reloads immediately
        sendc(8'h1C, 32'h41, 3'd1, 32'h42, 3'd1, 1'b0, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h41, 3'd1, 1'b1, 1'b0);
        sendc(8'h32, 32'h42, 3'd1, 32'h41, 3'd1, 1'b1, 1'b0);
        cmd_q.push_back('{w: 32'h41, l: 3'd1});
        @(posedge clock); #1;
        scan_data = 8'h5A; scan_valid = 1'b1; cmd_ready = 1'b1;
        @(posedge clock); #1;
        scan_valid = 1'b0; cmd_ready = 1'b0;
        push_snap(1'b1, 32'h0, 3'd0, 32'h42, 3'd1, 1'b1, 1'b0);
        accept(32'h42, 3'd1);
        push_snap(1'b1, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);

        // Extended make/break and unmapped keys are filtered
        send(8'hE0, 1'b0);
        sendc(8'h75, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        sendc(8'h75, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);
        sendc(8'h0E, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);
        sendc(8'h1C, 32'h41, 3'd1, 32'h42, 3'd1, 1'b0, 1'b0);
        sendc(8'h66, 32'h0, 3'd0, 32'h42, 3'd1, 1'b0, 1'b0);

        // Reset after a break prefix, with a strobe that must be ignored
        send(8'hF0, 1'b0);
        pulse_reset(8'h1C);
        sendc(8'h1C, 32'h41, 3'd1, 32'h0, 3'd0, 1'b0, 1'b0);
        sendc(8'h5A, 32'h0, 3'd0, 32'h41, 3'd1, 1'b1, 1'b0);
        sendc(8'h32, 32'h42, 3'd1, 32'h41, 3'd1, 1'b1, 1'b0);
        pulse_reset(8'h00);

        repeat (3) @(posedge clock);
        #1 done = 1'b1;
    end

endmodule

// File: doc/ps2_command_assembler.md
Name: ps2_command_assembler

Overview:
- Downstream of the PS/2 interface. Consumes the raw scan-code byte stream and keeps a short line buffer of typed characters.
- On Enter it issues the buffered characters, packed into one 32-bit command word, to the processor over a valid/ready handshake.
- Break codes, extended keys and unmapped keys are filtered out. Backspace edits the buffer.
- A live copy of the buffer drives the LCD/seven-segment debug path.

Parameters:
- MAX_CHARS, 4: buffer depth in characters. Must equal 32/8; the value is fixed for this revision.
- CNT_W, 3: width of the count fields. Equals clog2(MAX_CHARS+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scan_data  in  8  scan byte from the PS/2 interface.
- scan_valid  in  1  one-cycle strobe; scan_data is valid in this cycle.
- buf_word  out  32  live buffer, ASCII, right-aligned.
- buf_count  out  CNT_W  number of characters in the buffer, 0..4.
- cmd_word  out  32  committed command, ASCII, right-aligned, unused upper bytes 0.
- cmd_len  out  CNT_W  character count of cmd_word, 1..4.
- cmd_valid  out  1  command pending.
- cmd_ready  in  1  consumer accepts the command.
- overflow  out  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset values: reset wins over all other inputs.
  - All outputs are 0.
  - The prefix FSM is in NORMAL.
  - scan_valid is ignored during reset.
- Prefix FSM, advancing only on scan_valid:
  - NORMAL:
    - F0 -> BREAK.
    - E0 -> EXT.
    - Any other byte is a key event.
  - BREAK: any byte is swallowed -> NORMAL.
  - EXT:
    - F0 -> EXT_BREAK.
    - Any other byte is swallowed (extended make) -> NORMAL.
  - EXT_BREAK: any byte is swallowed -> NORMAL.
- Key event classification, in priority order:
  - 5A: Enter.
  - 66: Backspace.
  - Otherwise the byte goes through scancode_to_ascii.
    - Result 00 means unmapped; the byte is ignored with no overflow pulse.
    - A nonzero result is a printable character.
- Printable character:
  - If buf_count < MAX_CHARS:
    - buf_word <= {buf_word[23:0], ascii}.
    - buf_count + 1.
  - Otherwise the character is dropped and overflow pulses.
- Backspace:
  - If buf_count > 0:
    - buf_word <= {8'h00, buf_word[31:8]}.
    - buf_count - 1.
  - On an empty buffer, Backspace is a no-op with no pulse.
- Enter:
  - Empty buffer: no-op.
  - Non-empty buffer and cmd_valid = 0:
    - cmd_word <= buf_word.
    - cmd_len <= buf_count.
    - cmd_valid <= 1.
    - The buffer clears to 0 in the same edge.
  - Non-empty buffer and cmd_valid = 1 with cmd_ready = 0: Enter is dropped, overflow pulses, and the buffer is kept.
  - Non-empty buffer and cmd_valid = 1 with cmd_ready = 1 in the same cycle:
    - The old command retires.
    - The new command loads, so cmd_valid stays 1.
- Handshake:
  - cmd_valid rising -> cmd_word and cmd_len are held stable until the cycle in which cmd_valid & cmd_ready.
  - After that cycle, cmd_valid falls and cmd_word and cmd_len are unchanged.
  - cmd_ready while cmd_valid = 0 has no effect.
- Latency:
  - A scan_valid at edge N updates buf_* and overflow after edge N.
  - An Enter at edge N asserts cmd_valid after edge N, i.e. one cycle of registered latency.
- Typing while a command is pending is allowed; it fills the buffer normally.
- Typematic repeats are repeated make codes and count as separate presses.
- A mid-sequence reset (for example after F0 but before the next byte) returns the FSM to NORMAL, so the next byte is a key event.

Decomposition:
- Shared package ps2_keys_pkg:
  - Constants SC_BREAK = F0, SC_EXT = E0, SC_ENTER = 5A, SC_BKSP = 66.
  - Prefix-state enum {NORMAL, BREAK, EXT, EXT_BREAK}.
  - MAX_CHARS.
- One sub-module, scancode_to_ascii:
  - Purely combinational, 8-bit in to 8-bit out.
  - Maps set-2 codes for A-Z to 41-5A and 0-9 to 30-39; everything else maps to 00.
- The assembler instantiates it once, on scan_data.

Test Plan:
- Press F, then 2, each followed by its break code; then Enter:
  - Byte sequence 2B, F0 2B, 1E, F0 1E, 5A, F0 5A.
  - Required: cmd_valid = 1 with cmd_word = 00004632 and cmd_len = 2, and the buffer is 0.
- Type F D 1 0 then X (2B, 23, 16, 45, 22 with breaks):
  - buf_word = 46443130 and buf_count = 4.
  - The X causes an overflow pulse and the buffer is unchanged.
- Type R 9, then Backspace three times (2D, 46, 66, 66, 66):
  - The buffer goes 52 -> 5239 -> 52 -> 0.
  - The third Backspace gives no pulse.
  - Enter afterwards gives cmd_valid = 0.
- Hold cmd_ready = 0 and commit A (1C, 5A):
  - Type B (32), then Enter: the Enter is dropped, overflow pulses and buf_word = 42.
  - Raise cmd_ready for one cycle: cmd_valid falls.
  - Enter again: cmd_word = 00000042.
- Extended and unmapped keys:
  - Sequence E0 75, E0 F0 75, then 0E: buffer stays 0 with no pulses.
  - Next byte 1C: buffer = 41, showing the FSM returned to NORMAL.
- Reset mid-sequence:
  - Send F0, assert reset for 1 cycle, then send 1C: buffer = 41.
  - Asserting reset while cmd_valid = 1 clears all outputs to 0.
